// File: rtl/hld_pkg.sv
// Shared types, lamp/segment code constants and decode helpers for the
// traffic-light output monitor.
package hld_pkg;

    typedef enum logic [1:0] {
        PH_OFF    = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    // Lamp vector is active-low {y, g, r}; exactly one zero means one lamp lit.
    localparam logic [2:0] LAMP_RED    = 3'b110;
    localparam logic [2:0] LAMP_GREEN  = 3'b101;
    localparam logic [2:0] LAMP_YELLOW = 3'b011;
    localparam logic [2:0] LAMP_OFF    = 3'b111;

    localparam int F_LAMP  = 0;
    localparam int F_TRANS = 1;
    localparam int F_DWELL = 2;
    localparam int F_SEG   = 3;

    localparam int DWELL_W = 18;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] digit;
    } seg_dec_t;

    typedef struct packed {
        logic   ok;
        phase_t ph;
    } lamp_dec_t;

    function automatic seg_dec_t seg_decode(input logic [6:0] code);
        seg_dec_t r;
        r       = '0;
        r.valid = 1'b1;
        case (code)
            SEG_0:     r.digit = 4'd0;
            SEG_1:     r.digit = 4'd1;
            SEG_2:     r.digit = 4'd2;
            SEG_3:     r.digit = 4'd3;
            SEG_4:     r.digit = 4'd4;
            SEG_5:     r.digit = 4'd5;
            SEG_6:     r.digit = 4'd6;
            SEG_7:     r.digit = 4'd7;
            SEG_8:     r.digit = 4'd8;
            SEG_9:     r.digit = 4'd9;
            SEG_BLANK: begin
                r.valid = 1'b0;
                r.blank = 1'b1;
            end
            default:   r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic lamp_dec_t lamp_decode(input logic [2:0] lamp);
        lamp_dec_t r;
        r.ok = 1'b1;
        r.ph = PH_OFF;
        case (lamp)
            LAMP_RED:    r.ph = PH_RED;
            LAMP_GREEN:  r.ph = PH_GREEN;
            LAMP_YELLOW: r.ph = PH_YELLOW;
            LAMP_OFF:    r.ph = PH_OFF;
            default:     r.ok = 1'b0;
        endcase
        return r;
    endfunction

    // Dropping to OFF is always allowed; otherwise only the normal cycle.
    function automatic logic legal_step(input phase_t from, input phase_t to);
        logic r;
        r = 1'b0;
        case (to)
            PH_OFF:    r = 1'b1;
            PH_RED:    r = (from == PH_OFF) || (from == PH_YELLOW);
            PH_GREEN:  r = (from == PH_RED);
            PH_YELLOW: r = (from == PH_GREEN);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hld_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module hld_tick_gen #(
    parameter int TICK_DIV = 5000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hld_monitor.sv
// Passive checker for the traffic-light lamp and countdown-digit bus:
// decodes phase/digit, measures phase dwell and latches sticky faults.
module hld_monitor
    import hld_pkg::*;
#(
    parameter int TICK_DIV = 5000,
    parameter int T_S      = 10000,
    parameter int DWELL_R  = 11,
    parameter int DWELL_G  = 8,
    parameter int DWELL_Y  = 4,
    parameter int TOL      = 10
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [6:0]          led_in,
    input  logic [2:0]          lamp_in,
    input  logic                fault_clr,
    output logic [1:0]          phase,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                phase_done,
    output logic [DWELL_W-1:0]  dwell,
    output logic [3:0]          fault
);

    localparam logic [31:0] TGT_R = 32'(DWELL_R * T_S);
    localparam logic [31:0] TGT_G = 32'(DWELL_G * T_S);
    localparam logic [31:0] TGT_Y = 32'(DWELL_Y * T_S);
    localparam logic [31:0] TOL_U = 32'(TOL);

    logic [6:0]         led_s1, led_s2;
    logic [2:0]         lamp_s1, lamp_s2;
    phase_t             phase_q;
    logic [DWELL_W-1:0] cnt;
    logic               tick;

    seg_dec_t    seg;
    lamp_dec_t   lamp;
    logic        move;
    logic        checked;
    logic [31:0] target;
    logic [31:0] cnt32;
    logic [31:0] dev;
    logic [3:0]  ev;
    logic [3:0]  fault_d;

    hld_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    assign phase = phase_q;

    always_comb begin
        seg   = seg_decode(led_s1);
        lamp  = lamp_decode(lamp_s1);
        move  = lamp.ok && (lamp.ph != phase_q);
        // Leaving OFF carries no dwell requirement.
        checked = move && (phase_q != PH_OFF);

        target = '0;
        case (phase_q)
            PH_RED:    target = TGT_R;
            PH_GREEN:  target = TGT_G;
            PH_YELLOW: target = TGT_Y;
            default:   target = '0;
        endcase

        cnt32 = 32'(cnt);
        dev   = (cnt32 >= target) ? (cnt32 - target) : (target - cnt32);

        // Lamp and segment errors are raised once per new pattern so that a
        // held bad pattern does not defeat fault_clr.
        ev          = '0;
        ev[F_LAMP]  = (lamp_s1 != lamp_s2) && !lamp.ok;
        ev[F_TRANS] = move && !legal_step(phase_q, lamp.ph);
        ev[F_DWELL] = (checked && (dev > TOL_U)) ||
                      ((phase_q != PH_OFF) && (cnt32 > target + TOL_U));
        ev[F_SEG]   = (led_s1 != led_s2) && !seg.valid && !seg.blank;

        fault_d = fault_clr ? ev : (fault | ev);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_s1      <= '1;
            led_s2      <= '1;
            lamp_s1     <= '1;
            lamp_s2     <= '1;
            phase_q     <= PH_OFF;
            cnt         <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            phase_done  <= 1'b0;
            dwell       <= '0;
            fault       <= '0;
        end else begin
            led_s1  <= led_in;
            led_s2  <= led_s1;
            lamp_s1 <= lamp_in;
            lamp_s2 <= lamp_s1;

            fault      <= fault_d;
            phase_done <= checked;
            if (checked) begin
                dwell <= cnt;
            end

            digit_valid <= seg.valid;
            if (seg.valid) begin
                digit <= seg.digit;
            end

            // A tick landing on the change cycle is not counted.
            if (move) begin
                phase_q <= lamp.ph;
                cnt     <= '0;
            end else if (tick && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hld_monitor.sv
// Directed bench for hld_monitor with a dwell scoreboard on phase_done.
module tb_hld_monitor;

    localparam int TICK_DIV = 2;
    localparam int T_S      = 10;
    localparam int DWELL_R  = 11;
    localparam int DWELL_G  = 8;
    localparam int DWELL_Y  = 4;
    localparam int TOL      = 1;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [6:0]  led_in;
    logic [2:0]  lamp_in;
    logic        fault_clr;
    logic [1:0]  phase;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        phase_done;
    logic [17:0] dwell;
    logic [3:0]  fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_done = 0;
    logic [17:0] exp_q[$];

    hld_monitor #(
        .TICK_DIV (TICK_DIV),
        .T_S      (T_S),
        .DWELL_R  (DWELL_R),
        .DWELL_G  (DWELL_G),
        .DWELL_Y  (DWELL_Y),
        .TOL      (TOL)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .led_in      (led_in),
        .lamp_in     (lamp_in),
        .fault_clr   (fault_clr),
        .phase       (phase),
        .digit       (digit),
        .digit_valid (digit_valid),
        .phase_done  (phase_done),
        .dwell       (dwell),
        .fault       (fault)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        lamp_in   = 3'b111;
        led_in    = 7'b1111111;
        fault_clr = 1'b0;
        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_phase"},       32'(phase),       32'd0);
        check({tag, "_digit"},       32'(digit),       32'd0);
        check({tag, "_digit_valid"}, 32'(digit_valid), 32'd0);
        check({tag, "_phase_done"},  32'(phase_done),  32'd0);
        check({tag, "_dwell"},       32'(dwell),       32'd0);
        check({tag, "_fault"},       32'(fault),       32'd0);
    endtask

    // Drive a lamp pattern; if it ends a checked phase, queue its nominal dwell.
    task automatic drive_lamp(input logic [2:0] pat, input int exp_dwell);
        lamp_in = pat;
        if (exp_dwell >= 0) exp_q.push_back(18'(exp_dwell));
    endtask

    // scoreboard: dwell accepted within one tick of nominal
    always @(negedge sys_clk) begin
        if (sys_rst_n && phase_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_phase_done", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                int diff;
                e = exp_q.pop_front();
                diff = int'(dwell) - int'(e);
                check($sformatf("dwell_%0d_got_%0d", e, dwell),
                      32'((diff >= -1) && (diff <= 1)), 32'd1);
            end
        end
    end

    initial begin : stim
        int start;
        int elapsed;
        int waited;

        sys_rst_n = 1'b0;
        lamp_in   = 3'b111;
        led_in    = 7'b1111111;
        fault_clr = 1'b0;
        wait_cyc(3);
        check_reset_values("reset");
        sys_rst_n = 1'b1;
        wait_cyc(2);

        // 1: nominal red/green/yellow cycle
        drive_lamp(3'b110, -1);
        wait_cyc(2);
        check("t1_phase_red", 32'(phase), 32'd1);
        wait_cyc(218);
        drive_lamp(3'b101, 110);
        wait_cyc(2);
        check("t1_phase_green", 32'(phase), 32'd2);
        wait_cyc(158);
        drive_lamp(3'b011, 80);
        wait_cyc(2);
        check("t1_phase_yellow", 32'(phase), 32'd3);
        wait_cyc(78);
        drive_lamp(3'b110, 40);
        wait_cyc(2);
        check("t1_phase_red2", 32'(phase), 32'd1);
        check("t1_fault", 32'(fault), 32'd0);

        // 2: short red
        wait_cyc(178);
        drive_lamp(3'b101, 90);
        wait_cyc(2);
        check("t2_phase_green", 32'(phase), 32'd2);
        check("t2_fault", 32'(fault), 32'b0100);

        // 3: stuck green watchdog
        start = cyc;
        fault_clr = 1'b1;
        wait_cyc(1);
        fault_clr = 1'b0;
        wait_cyc(1);
        check("t3_fault_cleared", 32'(fault), 32'd0);
        wait_cyc(148);
        check("t3_no_early_fault", 32'(fault[2]), 32'd0);
        waited = 0;
        while (!fault[2] && waited < 60) begin
            wait_cyc(1);
            waited++;
        end
        elapsed = cyc - start;
        check("t3_watchdog_fired", 32'(fault[2]), 32'd1);
        check($sformatf("t3_watchdog_time_%0d", elapsed),
              32'((elapsed >= 160) && (elapsed <= 170)), 32'd1);
        check("t3_phase_held", 32'(phase), 32'd2);

        // 4: illegal transition, illegal lamp, clear
        do_reset();
        drive_lamp(3'b110, -1);
        wait_cyc(20);
        drive_lamp(3'b011, 10);
        wait_cyc(2);
        check("t4_phase_yellow", 32'(phase), 32'd3);
        check("t4_fault_trans", 32'(fault), 32'b0110);
        drive_lamp(3'b000, -1);
        wait_cyc(2);
        check("t4_phase_held", 32'(phase), 32'd3);
        check("t4_fault_lamp", 32'(fault), 32'b0111);
        fault_clr = 1'b1;
        wait_cyc(1);
        fault_clr = 1'b0;
        wait_cyc(1);
        check("t4_fault_clr", 32'(fault), 32'd0);

        // 5: segment decode
        do_reset();
        led_in = 7'b0000001;
        wait_cyc(2);
        check("t5_digit0", 32'(digit), 32'd0);
        check("t5_valid0", 32'(digit_valid), 32'd1);
        check("t5_fault0", 32'(fault), 32'd0);
        wait_cyc(2);
        led_in = 7'b1001111;
        wait_cyc(2);
        check("t5_digit1", 32'(digit), 32'd1);
        check("t5_valid1", 32'(digit_valid), 32'd1);
        check("t5_fault1", 32'(fault), 32'd0);
        wait_cyc(2);
        led_in = 7'b1111111;
        wait_cyc(2);
        check("t5_digit_blank", 32'(digit), 32'd1);
        check("t5_valid_blank", 32'(digit_valid), 32'd0);
        check("t5_fault_blank", 32'(fault), 32'd0);
        wait_cyc(2);
        led_in = 7'b0110110;
        wait_cyc(2);
        check("t5_digit_bad", 32'(digit), 32'd1);
        check("t5_valid_bad", 32'(digit_valid), 32'd0);
        check("t5_fault_bad", 32'(fault), 32'b1000);

        // 6: clear coincident with a new bad code, then reset mid-green
        drive_lamp(3'b000, -1);
        wait_cyc(2);
        check("t6_fault_pre", 32'(fault), 32'b1001);
        led_in = 7'b0110111;
        wait_cyc(1);
        fault_clr = 1'b1;
        wait_cyc(1);
        fault_clr = 1'b0;
        check("t6_fault_clr_coincident", 32'(fault), 32'b1000);

        do_reset();
        drive_lamp(3'b110, -1);
        wait_cyc(20);
        drive_lamp(3'b101, 10);
        wait_cyc(30);
        check("t6_phase_green", 32'(phase), 32'd2);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1 check_reset_values("async");
        lamp_in = 3'b111;
        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_cyc(10);
        check("t6_no_phase_done", 32'(phase_done), 32'd0);

        check("done_count", 32'(n_done), 32'd6);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hld_monitor.md
# hld_monitor

Passive checker on the traffic-light output bus: samples the active-low lamp vector and the active-low 7-segment countdown pattern produced by the light controller. It decodes the current phase and digit, measures each phase's dwell time on a 0.1 ms time base, and latches sticky fault flags on:
- illegal lamp patterns,
- illegal phase sequences,
- out-of-range dwell times,
- undecodable segment codes.

It sits beside the controller on the same clock and never drives the lamps.

## Interface
- TICK_DIV, 5000, sys_clk cycles per 0.1 ms tick (50 MHz)
- T_S, 10000, ticks per second
- DWELL_R, 11, required red dwell in seconds
- DWELL_G, 8, required green dwell in seconds
- DWELL_Y, 4, required yellow dwell in seconds
- TOL, 10, allowed dwell deviation in ticks (±)
- sys_clk  input  1  system clock; single clock domain
- sys_rst_n  input  1  asynchronous, active-low reset
- led_in  input  7  segment pattern {a,b,c,d,e,f,g}, active-low
- lamp_in  input  3  lamp vector, active-low; 110=RED, 101=GREEN, 011=YELLOW, 111=OFF
- fault_clr  input  1  one-cycle pulse, clears fault
- phase  output  2  0=OFF, 1=RED, 2=GREEN, 3=YELLOW
- digit  output  4  last validly decoded digit, 0–9
- digit_valid  output  1  high while the current led_in decodes
- phase_done  output  1  one-cycle pulse at each checked phase end
- dwell  output  18  measured ticks of the phase just ended; valid with phase_done
- fault  output  4  sticky; bit0 illegal lamp, bit1 illegal transition, bit2 dwell error, bit3 bad segment code

## Operation
**Input registration**
- led_in and lamp_in are registered twice (s1, s2).
- A change is detected when s1 != s2.

**Segment decode** (s1)
- Codes:
  - 0:0000001
  - 1:1001111
  - 2:0010010
  - 3:0000110
  - 4:1001100
  - 5:0100100
  - 6:0100000
  - 7:0001111
  - 8:0000000
  - 9:0000100
- 1111111 (blank) is legal: digit_valid=0, digit is held.
- Any other pattern: digit_valid=0, digit held, fault[3] set.

**Phase FSM** (OFF/RED/GREEN/YELLOW), driven by s1 lamp pattern
- Legal transitions: OFF→RED, RED→GREEN, GREEN→YELLOW, YELLOW→RED, any→OFF.
- Other valid-pattern transitions: move to the new phase anyway and set fault[1].
- Non-one-hot-low pattern (000, 001, 010, 100): phase held, fault[0] set.
  - The dwell counter keeps running.

**Tick and dwell counting**
- Tick prescaler counts 0..TICK_DIV-1; tick = terminal count.
- Dwell counter clears on each phase change and increments on tick.
- It saturates at 2^18-1.

**Dwell check** at each phase change out of RED/GREEN/YELLOW:
- dwell ← counter, phase_done pulses.
- fault[2] set if |counter − DWELL_x·T_S| > TOL.
- Exits from OFF are not checked and produce no phase_done.

**Stuck-lamp watchdog**
- In RED/GREEN/YELLOW, fault[2] sets as soon as counter > DWELL_x·T_S + TOL, without waiting for a transition.
- It then also sets at the eventual transition; the bit is idempotent.

**Fault register**
- fault bits are sticky until fault_clr.
- fault_clr in the same cycle as a new fault event: the new bit is set and other bits clear.

## Timing
- Reset values: phase=0, digit=0, digit_valid=0, phase_done=0, dwell=0, fault=0, prescaler=0, dwell counter=0, s1/s2=all ones.
- Latency: input change at edge N → phase, digit, digit_valid, fault, phase_done updated at edge N+2.
- phase_done is exactly one cycle wide; dwell holds until the next phase_done.
- Dwell resolution is one tick; counting starts at the first tick after the change cycle.
- Asynchronous reset mid-phase aborts measurement; no phase_done is issued.
- Prescaler runs freely from reset and is not realigned on phase change.

## Structure
- hld_pkg: phase enum (OFF/RED/GREEN/YELLOW), lamp pattern constants, fault bit indices, 7-seg code constants.
- hld_pkg also holds the function seg_decode(code) → {valid, blank, digit}.
- One natural sub-module: hld_tick_gen (prescaler, parameter TICK_DIV, output tick), reusable by the controller.
- The FSM, dwell check and fault register stay in hld_monitor.

## Test plan
All scenarios use TICK_DIV=2, T_S=10, DWELL_R=11, DWELL_G=8, DWELL_Y=4, TOL=1.
1. Reset, then lamp 111→110 held 220 cycles →101 held 160 →011 held 80 →110 → phase 1,2,3,1.
   - Three phase_done pulses with dwell≈110/80/40 ±1.
   - fault=0.
2. RED held only 180 cycles then GREEN → phase_done with dwell≈90, fault=4'b0100.
3. Stay in GREEN indefinitely → fault[2] sets when counter reaches 82 ticks, with phase still 2.
4. From RED drive 011 → phase=3, fault[1]=1.
   - Then drive 000 → phase stays 3, fault[0]=1.
   - fault_clr pulse → fault=0.
5. led_in sequence 0000001, 1001111, 1111111, 0110110 → digit 0, 1, 1(held), 1(held).
   - digit_valid 1, 1, 0, 0.
   - fault[3] set only on the last pattern.
6. fault_clr coincident with a bad segment code → fault=4'b1000.
   - Async reset asserted mid-GREEN → all outputs return to reset values immediately, with no phase_done.
